simd_alu_pipe: RTL

//  Parametrised successor to the warp ALU: NUM_LANES-wide SIMD integer/branch unit between operand collector (OC) and CDB.
//  Two-stage registered pipeline (E1 capture, E2 result) with valid/ready handshake to OC and a CDB grant for backpressure.

---
 rtl/simd_alu_pipe_if.sv | 64 ++++++
 rtl/simd_alu_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe_if.sv
// Bundle of OC->ALU issue, ALU->CDB writeback, ALU->SIMT branch and ALU->scoreboard clear signals.
// master = environment side (OC, CDB, SIMT, scoreboard); slave = the ALU.
interface simd_alu_pipe_if #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 32,
  parameter int WARP_W    = 3,
  parameter int SCB_W     = 2
);
  logic                          Valid_OC_ALU;
  logic                          Ready_ALU_OC;
  logic [NUM_LANES-1:0]          ActiveMask_OC_ALU;
  logic [WARP_W-1:0]             WarpID_OC_ALU;
  logic [31:0]                   Instr_OC_ALU;
  logic [NUM_LANES*DATA_W-1:0]   Src1_Data_OC_ALU;
  logic [NUM_LANES*DATA_W-1:0]   Src2_Data_OC_ALU;
  logic [4:0]                    Dst_OC_ALU;
  logic [15:0]                   Imme_OC_ALU;
  logic                          Imme_Valid_OC_ALU;
  logic                          RegWrite_OC_ALU;
  logic [3:0]                    ALUop_OC_ALU;
  logic                          BEQ_OC_ALU;
  logic                          BLT_OC_ALU;
  logic [SCB_W-1:0]              ScbID_OC_ALU;

  logic                          Grant_CDB_ALU;
  logic                          Valid_ALU_CDB;
  logic [NUM_LANES-1:0]          ActiveMask_ALU_CDB;
  logic [31:0]                   Instr_ALU_CDB;
  logic [WARP_W-1:0]             WarpID_ALU_CDB;
  logic                          RegWrite_ALU_CDB;
  logic [4:0]                    Dst_ALU_CDB;
  logic [NUM_LANES*DATA_W-1:0]   Dst_Data_ALU_CDB;

  logic                          Br_ALU_SIMT;
  logic [NUM_LANES-1:0]          BrOutcome_ALU_SIMT;
  logic [WARP_W-1:0]             WarpID_ALU_SIMT;
  logic [31:0]                   TargetAddr_ALU_PC;

  logic                          Clear_Valid_ALU_Scb;
  logic [WARP_W-1:0]             Clear_WarpID_ALU_Scb;
  logic [SCB_W-1:0]              Clear_ScbID_ALU_Scb;

  modport master (
    output Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
           Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
           Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU, BEQ_OC_ALU,
           BLT_OC_ALU, ScbID_OC_ALU, Grant_CDB_ALU,
    input  Ready_ALU_OC, Valid_ALU_CDB, ActiveMask_ALU_CDB, Instr_ALU_CDB,
           WarpID_ALU_CDB, RegWrite_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB,
           Br_ALU_SIMT, BrOutcome_ALU_SIMT, WarpID_ALU_SIMT, TargetAddr_ALU_PC,
           Clear_Valid_ALU_Scb, Clear_WarpID_ALU_Scb, Clear_ScbID_ALU_Scb
  );

  modport slave (
    input  Valid_OC_ALU, ActiveMask_OC_ALU, WarpID_OC_ALU, Instr_OC_ALU,
           Src1_Data_OC_ALU, Src2_Data_OC_ALU, Dst_OC_ALU, Imme_OC_ALU,
           Imme_Valid_OC_ALU, RegWrite_OC_ALU, ALUop_OC_ALU, BEQ_OC_ALU,
           BLT_OC_ALU, ScbID_OC_ALU, Grant_CDB_ALU,
    output Ready_ALU_OC, Valid_ALU_CDB, ActiveMask_ALU_CDB, Instr_ALU_CDB,
           WarpID_ALU_CDB, RegWrite_ALU_CDB, Dst_ALU_CDB, Dst_Data_ALU_CDB,
           Br_ALU_SIMT, BrOutcome_ALU_SIMT, WarpID_ALU_SIMT, TargetAddr_ALU_PC,
           Clear_Valid_ALU_Scb, Clear_WarpID_ALU_Scb, Clear_ScbID_ALU_Scb
  );
endinterface

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD integer/branch ALU (E1 operand capture, E2 result) between OC and CDB.
// Define SIMD_ALU_SAT_EN for saturating add/sub (ops 0/1) and unsigned saturating ops 12/13.
module simd_alu_pipe #(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 32,
  parameter int WARP_W    = 3,
  parameter int SCB_W     = 2
) (
  input logic            clk,
  input logic            rst,
  simd_alu_pipe_if.slave bus
);
  localparam int LW   = NUM_LANES * DATA_W;
  localparam int HALF = DATA_W / 2;
  localparam int MSB  = DATA_W - 1;
  // Shift amount comes from Imme[11:7], never wider than that field.
  localparam int SH_W = ($clog2(DATA_W) > 5) ? 5 : $clog2(DATA_W);
`ifdef SIMD_ALU_SAT_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic                 e1_valid_reg;
  logic [NUM_LANES-1:0] e1_mask_reg;
  logic [WARP_W-1:0]    e1_warp_reg;
  logic [31:0]          e1_instr_reg;
  logic [LW-1:0]        e1_src1_reg;
  logic [LW-1:0]        e1_src2_reg;
  logic [4:0]           e1_dst_reg;
  logic [15:0]          e1_imme_reg;
  logic                 e1_immv_reg;
  logic                 e1_rw_reg;
  logic [3:0]           e1_op_reg;
  logic                 e1_beq_reg;
  logic                 e1_blt_reg;
  logic [SCB_W-1:0]     e1_scb_reg;

  logic                 e2_wb_reg;
  logic                 e2_br_reg;
  logic [NUM_LANES-1:0] e2_mask_reg;
  logic [WARP_W-1:0]    e2_warp_reg;
  logic [31:0]          e2_instr_reg;
  logic                 e2_rw_reg;
  logic [4:0]           e2_dst_reg;
  logic [LW-1:0]        e2_data_reg;
  logic [NUM_LANES-1:0] e2_outcome_reg;
  logic [15:0]          e2_target_reg;
  logic [SCB_W-1:0]     e2_scb_reg;

  logic                 stall;
  logic                 accept;
  logic                 imm_op;
  logic                 use_imm;
  logic [DATA_W-1:0]    imm_sx;
  logic [SH_W-1:0]      shamt;
  logic [LW-1:0]        lane_res;
  logic [NUM_LANES-1:0] lane_taken;

  // Only a pending register write can block; branches in E2 always retire.
  assign stall            = e2_wb_reg & ~bus.Grant_CDB_ALU;
  assign bus.Ready_ALU_OC = rst & ~stall;
  assign accept           = bus.Valid_OC_ALU & bus.Ready_ALU_OC;

  always_comb begin
    imm_op = 1'b0;
    case (e1_op_reg)
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10: imm_op = 1'b1;
      default:                                        imm_op = 1'b0;
    endcase
  end

  assign use_imm = e1_immv_reg & imm_op;
  assign imm_sx  = {{(DATA_W-16){e1_imme_reg[15]}}, e1_imme_reg};
  assign shamt   = e1_imme_reg[7 +: SH_W];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [DATA_W-1:0] a, b, op2, sum, diff, prod, res;
      logic [DATA_W-1:0] add_res, sub_res, uadd_res, usub_res;
      logic              lt;

      assign a    = e1_src1_reg[gi*DATA_W +: DATA_W];
      assign b    = e1_src2_reg[gi*DATA_W +: DATA_W];
      assign op2  = use_imm ? imm_sx : b;
      assign sum  = a + op2;
      assign diff = a - op2;
      assign prod = {{(DATA_W-HALF){1'b0}}, a[HALF-1:0]} * {{(DATA_W-HALF){1'b0}}, b[HALF-1:0]};
      assign lt   = $signed(a) < $signed(op2);

`ifdef SIMD_ALU_SAT_EN
      logic [DATA_W:0] usum;
      assign usum     = {1'b0, a} + {1'b0, b};
      assign add_res  = ((a[MSB] == op2[MSB]) && (sum[MSB] != a[MSB]))  ? (a[MSB] ? SMIN : SMAX) : sum;
      assign sub_res  = ((a[MSB] != op2[MSB]) && (diff[MSB] != a[MSB])) ? (a[MSB] ? SMIN : SMAX) : diff;
      assign uadd_res = usum[DATA_W] ? {DATA_W{1'b1}} : usum[DATA_W-1:0];
      assign usub_res = (a < b) ? '0 : (a - b);
`else
      assign add_res  = sum;
      assign sub_res  = diff;
      assign uadd_res = '0;
      assign usub_res = '0;
`endif

      always_comb begin
        res = '0;
        case (e1_op_reg)
          4'd0:    res = add_res;
          4'd1:    res = sub_res;
          4'd2:    res = prod;
          4'd3:    res = a & op2;
          4'd4:    res = a | op2;
          4'd5:    res = a ^ op2;
          4'd6:    res = $signed(a) >>> shamt;
          4'd7:    res = a << shamt;
          4'd8:    res = {{(DATA_W-1){1'b0}}, lt};
          4'd9:    res = lt ? a : op2;
          4'd10:   res = lt ? op2 : a;
          4'd12:   res = uadd_res;
          4'd13:   res = usub_res;
          default: res = '0;
        endcase
      end

      assign lane_res[gi*DATA_W +: DATA_W] = e1_mask_reg[gi] ? res : '0;
      assign lane_taken[gi] = e1_mask_reg[gi] &
                              (e1_beq_reg ? (a == b) : ($signed(a) < $signed(b)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e1_valid_reg <= 1'b0;
      e1_mask_reg  <= '0;
      e1_warp_reg  <= '0;
      e1_instr_reg <= '0;
      e1_src1_reg  <= '0;
      e1_src2_reg  <= '0;
      e1_dst_reg   <= '0;
      e1_imme_reg  <= '0;
      e1_immv_reg  <= 1'b0;
      e1_rw_reg    <= 1'b0;
      e1_op_reg    <= '0;
      e1_beq_reg   <= 1'b0;
      e1_blt_reg   <= 1'b0;
      e1_scb_reg   <= '0;
    end else if (!stall) begin
      e1_valid_reg <= accept;
      if (accept) begin
        e1_mask_reg  <= bus.ActiveMask_OC_ALU;
        e1_warp_reg  <= bus.WarpID_OC_ALU;
        e1_instr_reg <= bus.Instr_OC_ALU;
        e1_src1_reg  <= bus.Src1_Data_OC_ALU;
        e1_src2_reg  <= bus.Src2_Data_OC_ALU;
        e1_dst_reg   <= bus.Dst_OC_ALU;
        e1_imme_reg  <= bus.Imme_OC_ALU;
        e1_immv_reg  <= bus.Imme_Valid_OC_ALU;
        e1_rw_reg    <= bus.RegWrite_OC_ALU;
        e1_op_reg    <= bus.ALUop_OC_ALU;
        e1_beq_reg   <= bus.BEQ_OC_ALU;
        e1_blt_reg   <= bus.BLT_OC_ALU;
        e1_scb_reg   <= bus.ScbID_OC_ALU;
      end
    end
  end

  // A register write outranks the branch flags; with neither the instruction just evaporates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e2_wb_reg      <= 1'b0;
      e2_br_reg      <= 1'b0;
      e2_mask_reg    <= '0;
      e2_warp_reg    <= '0;
      e2_instr_reg   <= '0;
      e2_rw_reg      <= 1'b0;
      e2_dst_reg     <= '0;
      e2_data_reg    <= '0;
      e2_outcome_reg <= '0;
      e2_target_reg  <= '0;
      e2_scb_reg     <= '0;
    end else if (!stall) begin
      e2_wb_reg <= e1_valid_reg & e1_rw_reg;
      e2_br_reg <= e1_valid_reg & ~e1_rw_reg & (e1_beq_reg | e1_blt_reg);
      if (e1_valid_reg) begin
        e2_mask_reg    <= e1_mask_reg;
        e2_warp_reg    <= e1_warp_reg;
        e2_instr_reg   <= e1_instr_reg;
        e2_rw_reg      <= e1_rw_reg;
        e2_dst_reg     <= e1_dst_reg;
        e2_data_reg    <= lane_res;
        e2_outcome_reg <= lane_taken;
        e2_target_reg  <= e1_imme_reg;
        e2_scb_reg     <= e1_scb_reg;
      end
    end
  end

  assign bus.Valid_ALU_CDB        = e2_wb_reg;
  assign bus.ActiveMask_ALU_CDB   = e2_mask_reg;
  assign bus.Instr_ALU_CDB        = e2_instr_reg;
  assign bus.WarpID_ALU_CDB       = e2_warp_reg;
  assign bus.RegWrite_ALU_CDB     = e2_rw_reg;
  assign bus.Dst_ALU_CDB          = e2_dst_reg;
  assign bus.Dst_Data_ALU_CDB     = e2_data_reg;
  assign bus.Br_ALU_SIMT          = e2_br_reg;
  assign bus.BrOutcome_ALU_SIMT   = e2_outcome_reg;
  assign bus.WarpID_ALU_SIMT      = e2_warp_reg;
  assign bus.TargetAddr_ALU_PC    = {16'b0, e2_target_reg};
  assign bus.Clear_Valid_ALU_Scb  = e2_br_reg;
  assign bus.Clear_WarpID_ALU_Scb = e2_warp_reg;
  assign bus.Clear_ScbID_ALU_Scb  = e2_scb_reg;
endmodule
